// File: rtl/egress_arbiter.sv
// Per-port egress arbiter: round-robin, frame-locked merge of tdest-tagged streams with a stall watchdog.
// Optional EGRESS_ARB_FRAME_CTR_EN adds saturating forwarded/aborted frame counters.
module egress_arbiter #(
    parameter int         NUM_INPUTS        = 4,
    parameter logic [1:0] PORT_ID           = 2'd0,
    parameter int         TIMEOUT_CTR_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_INPUTS-1:0]     ingress_tvalid,
    input  logic [16*NUM_INPUTS-1:0]  ingress_tdata,
    input  logic [2*NUM_INPUTS-1:0]   ingress_tdest,
    input  logic [NUM_INPUTS-1:0]     ingress_tlast,
    output logic [NUM_INPUTS-1:0]     ingress_tready,
    output logic                      egress_tvalid,
    output logic [15:0]               egress_tdata,
    output logic                      egress_tlast,
    output logic                      egress_tuser,
    input  logic                      egress_tready
`ifdef EGRESS_ARB_FRAME_CTR_EN
    ,
    output logic [15:0]               frames_fwd,
    output logic [7:0]                frames_abort
`endif
);

    // state   | meaning
    // IDLE    | no grant held; pick next requester after rr_ptr
    // FORWARD | granted input's beats move into the output register
    // DRAIN   | frame was aborted; discard granted input up to tlast
    typedef enum logic [1:0] {IDLE, FORWARD, DRAIN} state_t;

    localparam int GW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [TIMEOUT_CTR_WIDTH-1:0] STALL_ONE = TIMEOUT_CTR_WIDTH'(1);
    localparam logic [TIMEOUT_CTR_WIDTH-1:0] STALL_MAX = '1;
    localparam logic [TIMEOUT_CTR_WIDTH-1:0] STALL_PRE = STALL_MAX - STALL_ONE;

    state_t                       state;
    logic [GW-1:0]                grant;
    logic [GW-1:0]                rr_ptr;
    logic [GW-1:0]                next_grant;
    logic                         any_req;
    logic [TIMEOUT_CTR_WIDTH-1:0] stall_ctr;
    logic [NUM_INPUTS-1:0]        req;
    logic [15:0]                  in_data [NUM_INPUTS];
    logic                         accept_ok;

    assign accept_ok = !egress_tvalid || egress_tready;

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_port
        assign in_data[g]        = ingress_tdata[16*g +: 16];
        assign req[g]            = ingress_tvalid[g] && (ingress_tdest[2*g +: 2] == PORT_ID);
        assign ingress_tready[g] = (grant == GW'(g)) &&
                                   ((state == FORWARD && accept_ok) || state == DRAIN);
    end

    // Descending scan so the nearest requester after rr_ptr is the last to assign.
    always_comb begin
        any_req    = 1'b0;
        next_grant = rr_ptr;
        for (int k = NUM_INPUTS; k >= 1; k--) begin
            if (req[GW'((int'(rr_ptr) + k) % NUM_INPUTS)]) begin
                any_req    = 1'b1;
                next_grant = GW'((int'(rr_ptr) + k) % NUM_INPUTS);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            grant         <= '0;
            rr_ptr        <= GW'(NUM_INPUTS - 1);
            stall_ctr     <= '0;
            egress_tvalid <= 1'b0;
            egress_tdata  <= '0;
            egress_tlast  <= 1'b0;
            egress_tuser  <= 1'b0;
`ifdef EGRESS_ARB_FRAME_CTR_EN
            frames_fwd    <= '0;
            frames_abort  <= '0;
`endif
        end else begin
            if (egress_tready) begin
                egress_tvalid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant <= next_grant;
                        state <= FORWARD;
                    end
                end
                FORWARD: begin
                    if (ingress_tvalid[grant] && accept_ok) begin
                        egress_tvalid <= 1'b1;
                        egress_tdata  <= in_data[grant];
                        egress_tlast  <= ingress_tlast[grant];
                        egress_tuser  <= 1'b0;
                        stall_ctr     <= '0;
                        if (ingress_tlast[grant]) begin
                            rr_ptr <= grant;
                            state  <= IDLE;
`ifdef EGRESS_ARB_FRAME_CTR_EN
                            if (frames_fwd != '1) frames_fwd <= frames_fwd + 16'd1;
`endif
                        end
                    end else if (!ingress_tvalid[grant]) begin
                        // The stalled cycle that brings the count to its maximum fires the abort.
                        if (stall_ctr >= STALL_PRE && accept_ok) begin
                            egress_tvalid <= 1'b1;
                            egress_tdata  <= '0;
                            egress_tlast  <= 1'b1;
                            egress_tuser  <= 1'b1;
                            stall_ctr     <= '0;
                            state         <= DRAIN;
`ifdef EGRESS_ARB_FRAME_CTR_EN
                            if (frames_abort != '1) frames_abort <= frames_abort + 8'd1;
`endif
                        end else if (stall_ctr != STALL_MAX) begin
                            stall_ctr <= stall_ctr + STALL_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (ingress_tvalid[grant] && ingress_tlast[grant]) begin
                        rr_ptr <= grant;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_egress_arbiter.sv
// Self-checking bench for egress_arbiter: directed scenarios plus randomized traffic
// against a per-input frame scoreboard and a round-robin order model.
module tb_egress_arbiter;
    localparam int         N   = 4;
    localparam logic [1:0] PID = 2'd1;
    localparam int         TW  = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   in_valid;
    logic [16*N-1:0] in_data;
    logic [2*N-1:0] in_dest;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [15:0]    out_data;
    logic           out_last;
    logic           out_user;
    logic           out_ready;
`ifdef EGRESS_ARB_FRAME_CTR_EN
    logic [15:0]    frames_fwd;
    logic [7:0]     frames_abort;
`endif

    egress_arbiter #(.NUM_INPUTS(N), .PORT_ID(PID), .TIMEOUT_CTR_WIDTH(TW)) dut (
        .clk(clk), .reset(reset),
        .ingress_tvalid(in_valid), .ingress_tdata(in_data), .ingress_tdest(in_dest),
        .ingress_tlast(in_last), .ingress_tready(in_ready),
        .egress_tvalid(out_valid), .egress_tdata(out_data), .egress_tlast(out_last),
        .egress_tuser(out_user), .egress_tready(out_ready)
`ifdef EGRESS_ARB_FRAME_CTR_EN
        , .frames_fwd(frames_fwd), .frames_abort(frames_abort)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [15:0] data; logic last; logic user; int at; } obeat_t;
    typedef struct { int src; logic [15:0] data; logic last; int at; } ibeat_t;
    obeat_t      out_log[$];
    ibeat_t      in_log[$];
    logic [16:0] exp_q[N][$];
    bit          sb_on = 0;
    bit          in_frame = 0;
    int          cur_src = 0;
    int          fwd_cnt = 0;
    int          abort_cnt = 0;
    bit          prev_stall = 0;
    logic [18:0] prev_out = '0;
    bit          rand_done = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic score(logic [15:0] d, logic l, logic u);
        int          src;
        bit          have;
        logic [16:0] e;
        src = int'(d[15:13]);
        chk("sb_user", u, 1'b0);
        if (in_frame) chk("sb_interleave", src, cur_src);
        cur_src  = src;
        in_frame = !l;
        have = (src < N) && (exp_q[src].size() > 0);
        chk("sb_have_expected", have, 1'b1);
        if (have) begin
            e = exp_q[src].pop_front();
            chk("sb_data", d, e[15:0]);
            chk("sb_last", l, e[16]);
        end
    endtask

    // Monitor: samples on the falling edge, well away from the active edge.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            prev_stall = 0; fwd_cnt = 0; abort_cnt = 0; in_frame = 0;
        end else begin
            if (prev_stall) chk("hold_stable", {out_valid, out_user, out_last, out_data}, prev_out);
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_valid, out_user, out_last, out_data};
            for (int i = 0; i < N; i++)
                if (in_valid[i] && in_ready[i])
                    in_log.push_back('{i, in_data[16*i +: 16], in_last[i], cyc});
            if (out_valid && out_ready) begin
                out_log.push_back('{out_data, out_last, out_user, cyc});
                if (out_last) begin
                    if (out_user) abort_cnt++;
                    else fwd_cnt++;
                end
                if (sb_on) score(out_data, out_last, out_user);
            end
        end
    end

    task automatic wait_cycles(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_beat(int i, logic [15:0] d, logic [1:0] dest, logic last);
        bit ok = 0;
        in_valid[i] = 1'b1;
        in_data[16*i +: 16] = d;
        in_dest[2*i +: 2] = dest;
        in_last[i] = last;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready[i];
            @(posedge clk); #1;
        end
        in_valid[i] = 1'b0;
        chk("beat_accepted", ok, 1'b1);
    endtask

    task automatic wait_out(int n);
        for (int k = 0; k < 200 && out_log.size() < n; k++) wait_cycles(1);
        wait_cycles(4);
        chk("out_count", out_log.size(), n);
    endtask

    task automatic expect_out(string tag, int k, logic [15:0] d, logic l, logic u);
        if (k < out_log.size())
            chk(tag, {out_log[k].user, out_log[k].last, out_log[k].data}, {u, l, d});
        else
            chk({tag, "_missing"}, out_log.size(), k + 1);
    endtask

    task automatic do_reset();
        in_valid = '0; in_last = '0; in_data = '0; in_dest = '0;
        reset = 1'b0;
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(1);
    endtask

    task automatic rr_driver(int i);
        for (int f = 0; f < 2; f++)
            for (int b = 0; b < 2; b++)
                send_beat(i, 16'(i*256 + f*16 + b), PID, b == 1);
    endtask

    task automatic rand_driver(int i);
        int          len;
        logic [1:0]  d;
        logic [15:0] w;
        for (int f = 0; f < 8; f++) begin
            wait_cycles($urandom_range(3, 0));
            if ($urandom_range(4, 0) == 0) begin
                d = PID + 2'($urandom_range(3, 1));
                in_valid[i] = 1'b1;
                in_dest[2*i +: 2] = d;
                in_data[16*i +: 16] = {3'(i), 13'h1fff};
                in_last[i] = 1'b1;
                repeat ($urandom_range(5, 2)) begin
                    @(negedge clk);
                    chk("foreign_ready", in_ready[i], 1'b0);
                    @(posedge clk); #1;
                end
                in_valid[i] = 1'b0;
            end else begin
                len = $urandom_range(4, 1);
                for (int b = 0; b < len; b++) begin
                    w = {3'(i), 13'($urandom)};
                    exp_q[i].push_back({b == len - 1, w});
                    send_beat(i, w, (b == 0) ? PID : 2'($urandom), b == len - 1);
                    if (b < len - 1) wait_cycles($urandom_range(2, 0));
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    int          t0;
    int          rem[N];
    int          exp_src[6];
    int          fcnt[N];
    int          p;
    int          c;
    int          src;
    logic [15:0] bp_data[4];
    bit          bp_pat[16];

    initial begin
        reset = 1'b0; in_valid = '0; in_data = '0; in_dest = '0; in_last = '0; out_ready = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_fields", {out_data, out_last, out_user}, 18'h0);
        chk("rst_in_ready", in_ready, 4'h0);
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(2);

        // Basic 3-beat frame from input 2
        out_log.delete();
        t0 = cyc;
        send_beat(2, 16'h00A1, PID, 1'b0);
        send_beat(2, 16'h00A2, PID, 1'b0);
        send_beat(2, 16'h00A3, PID, 1'b1);
        wait_out(3);
        if (out_log.size() > 0) chk("basic_latency", out_log[0].at, t0 + 2);
        expect_out("basic_b0", 0, 16'h00A1, 1'b0, 1'b0);
        expect_out("basic_b1", 1, 16'h00A2, 1'b0, 1'b0);
        expect_out("basic_b2", 2, 16'h00A3, 1'b1, 1'b0);

        // Foreign destination is never granted
        out_log.delete();
        in_valid[0] = 1'b1; in_dest[1:0] = 2'd2; in_data[15:0] = 16'h0BAD; in_last[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("filter_ready", in_ready[0], 1'b0);
            chk("filter_out_valid", out_valid, 1'b0);
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        chk("filter_out_count", out_log.size(), 0);

        // Backpressure with a long stall while the input keeps offering
        out_log.delete();
        bp_data = '{16'hB000, 16'hB001, 16'hB002, 16'hB003};
        bp_pat  = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        fork
            for (int b = 0; b < 4; b++) send_beat(1, bp_data[b], PID, b == 3);
            begin
                for (int k = 0; k < 16; k++) begin out_ready = bp_pat[k]; wait_cycles(1); end
                out_ready = 1'b1;
            end
        join
        wait_out(4);
        for (int b = 0; b < 4; b++) expect_out("bp_beat", b, bp_data[b], b == 3, 1'b0);

        // Watchdog abort after 7 idle cycles, late beats drained, next frame normal
        out_log.delete();
        send_beat(1, 16'hC001, PID, 1'b0);
        send_beat(1, 16'hC002, PID, 1'b0);
        wait_cycles(7);
        send_beat(1, 16'hD001, PID, 1'b0);
        send_beat(1, 16'hD002, PID, 1'b0);
        send_beat(1, 16'hD003, PID, 1'b1);
        send_beat(0, 16'hE001, PID, 1'b0);
        send_beat(0, 16'hE002, PID, 1'b1);
        wait_out(5);
        expect_out("wd_b0", 0, 16'hC001, 1'b0, 1'b0);
        expect_out("wd_b1", 1, 16'hC002, 1'b0, 1'b0);
        expect_out("wd_abort", 2, 16'h0000, 1'b1, 1'b1);
        expect_out("wd_next0", 3, 16'hE001, 1'b0, 1'b0);
        expect_out("wd_next1", 4, 16'hE002, 1'b1, 1'b0);

        // A beat arriving on the threshold cycle wins over the abort
        out_log.delete();
        send_beat(2, 16'hF001, PID, 1'b0);
        wait_cycles(6);
        send_beat(2, 16'hF002, PID, 1'b1);
        wait_out(2);
        expect_out("edge_b0", 0, 16'hF001, 1'b0, 1'b0);
        expect_out("edge_b1", 1, 16'hF002, 1'b1, 1'b0);
`ifdef EGRESS_ARB_FRAME_CTR_EN
        chk("ctr_fwd_a", frames_fwd, fwd_cnt);
        chk("ctr_abort_a", frames_abort, abort_cnt);
`endif

        // Round-robin from reset among inputs 0, 1, 3
        do_reset();
        in_log.delete(); out_log.delete();
        rem = '{2, 2, 0, 2};
        p = N - 1;
        for (int k = 0; k < 6; k++) begin
            for (int s = 1; s <= N; s++) begin
                c = (p + s) % N;
                if (rem[c] > 0) begin exp_src[k] = c; rem[c]--; p = c; break; end
            end
        end
        fork
            rr_driver(0);
            rr_driver(1);
            rr_driver(3);
        join
        wait_out(12);
        chk("rr_in_count", in_log.size(), 12);
        fcnt = '{0, 0, 0, 0};
        for (int k = 0; k < 12; k++) begin
            src = exp_src[k/2];
            if (k < in_log.size()) chk("rr_grant", in_log[k].src, src);
            expect_out("rr_out", k, 16'(src*256 + fcnt[src]*16 + k%2), k%2 == 1, 1'b0);
            if (k % 2 == 1) fcnt[src]++;
        end

        // Asynchronous reset during beat 2 of a 4-beat frame
        send_beat(2, 16'h5A00, PID, 1'b0);
        in_valid[2] = 1'b1; in_data[47:32] = 16'h5A01; in_last[2] = 1'b0;
        #2;
        chk("pre_reset_valid", out_valid, 1'b1);
        reset = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_in_ready", in_ready, 4'h0);
        in_valid = '0;
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(1);
        out_log.delete();
        t0 = cyc;
        send_beat(3, 16'h3300, PID, 1'b0);
        send_beat(3, 16'h3301, PID, 1'b1);
        wait_out(2);
        if (out_log.size() > 0) chk("post_reset_latency", out_log[0].at, t0 + 2);
        expect_out("post_reset_b0", 0, 16'h3300, 1'b0, 1'b0);
        expect_out("post_reset_b1", 1, 16'h3301, 1'b1, 1'b0);

        // Randomized traffic against the per-input scoreboard
        for (int i = 0; i < N; i++) exp_q[i].delete();
        in_frame = 0;
        sb_on = 1;
        fork
            begin
                fork
                    rand_driver(0);
                    rand_driver(1);
                    rand_driver(2);
                    rand_driver(3);
                join
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(9, 0) < 7);
                    wait_cycles(1);
                end
                out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 100 && out_valid; k++) wait_cycles(1);
        wait_cycles(3);
        sb_on = 0;
        for (int i = 0; i < N; i++) chk("sb_leftover", exp_q[i].size(), 0);
`ifdef EGRESS_ARB_FRAME_CTR_EN
        chk("ctr_fwd_b", frames_fwd, fwd_cnt);
        chk("ctr_abort_b", frames_abort, abort_cnt);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/egress_arbiter.md
Name: egress_arbiter

Overview:
- Downstream neighbour of the ingress filter stage; one instance per egress port.
- Collects the tdest-tagged AXI-Stream outputs of NUM_INPUTS ingress filters and accepts only beats whose tdest equals PORT_ID.
- Grants one input at a time with round-robin fairness and frame locking: a grant is held from the first beat through tlast.
- Drives a single registered AXI-Stream egress with a stall watchdog that aborts hung frames.

Parameters:
- NUM_INPUTS, 4: number of ingress filter streams (2..8).
- PORT_ID, 0: 2-bit egress index that this instance serves.
- TIMEOUT_CTR_WIDTH, 3: stall watchdog width; abort after 2**W-1 consecutive stalled cycles.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- ingress_tvalid  in  NUM_INPUTS  per-input valid.
- ingress_tdata  in  16*NUM_INPUTS  per-input data; input i occupies [16i+15:16i].
- ingress_tdest  in  2*NUM_INPUTS  per-input destination; input i occupies [2i+1:2i].
- ingress_tlast  in  NUM_INPUTS  per-input end of frame.
- ingress_tready  out  NUM_INPUTS  per-input ready.
- egress_tvalid  out  1  output valid.
- egress_tdata  out  16  output data.
- egress_tlast  out  1  output end of frame.
- egress_tuser  out  1  abort marker; valid only with egress_tlast.
- egress_tready  in  1  downstream ready.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, grant=0, rr_ptr=NUM_INPUTS-1, stall_ctr=0.
  - egress_tvalid/tdata/tlast/tuser=0; ingress_tready=0.
- Request: req[i] = ingress_tvalid[i] && ingress_tdest[i]==PORT_ID.
- Output register: a single-entry register. accept_ok = !egress_tvalid || egress_tready. egress_* are held stable while egress_tvalid && !egress_tready.
- ingress_tready[i] = (state==FORWARD && grant==i && accept_ok) || (state==DRAIN && grant==i). It is 0 for all other inputs, and for every input in IDLE.
- IDLE:
  - If any req, set grant to the first requester strictly after rr_ptr (modulo NUM_INPUTS); next state FORWARD.
  - Arbitration costs one cycle; no beat is accepted in IDLE.
- FORWARD:
  - On ingress_tvalid[grant] && ingress_tready[grant]: load the beat into the output register (latency 1 cycle) and clear stall_ctr.
  - If that beat has tlast: set rr_ptr=grant and go to IDLE. One bubble cycle between frames is required.
  - tdest is checked only at grant time; mid-frame tdest changes are ignored.
  - If ingress_tvalid[grant]=0, increment stall_ctr, saturating.
  - When stall_ctr reaches 2**W-1 and accept_ok: load an abort beat (tdata=0, tlast=1, tuser=1), clear stall_ctr, go to DRAIN.
  - Backpressure stalls (egress_tready=0) do not count toward the timeout.
- DRAIN:
  - Sink and discard beats from the granted input (tready=1) until a tlast beat is accepted, then set rr_ptr=grant and go to IDLE.
  - No watchdog runs in DRAIN.
- Boundary cases:
  - Single-beat frame (tlast on the first beat): FORWARD lasts one accept, then IDLE.
  - Simultaneous abort threshold and tvalid arrival: the beat wins; stall_ctr clears and no abort is issued.
  - Reset mid-frame: output is cleared immediately; a partial frame already emitted is not terminated (downstream must handle it).
  - rr_ptr wraps from NUM_INPUTS-1 to 0.
  - With a single requester, that requester is regranted every frame.
- Normal beats drive egress_tuser=0.

Optional Feature:
- Macro: EGRESS_ARB_FRAME_CTR_EN.
- When defined, adds two outputs:
  - frames_fwd (16, out): count of frames completed without abort.
  - frames_abort (8, out): count of aborted frames.
- Both counters saturate, reset to 0, and increment in the cycle the final tlast beat loads into the output register.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Basic forwarding:
  - Stimulus: PORT_ID=1; input 2 sends a 3-beat frame 0xA1,0xA2,0xA3 with tdest=1; egress_tready=1.
  - Required: egress shows the same three beats, tlast on 0xA3, tuser=0; first egress beat appears 2 cycles after tvalid rises.
- Round-robin:
  - Stimulus: inputs 0, 1, 3 each continuously offer 2-beat frames with tdest=PORT_ID, starting from reset.
  - Required: grant order 0,1,3,0,1,3; no interleaving of beats within a frame.
- Destination filtering:
  - Stimulus: input 0 offers tdest=2 while PORT_ID=0.
  - Required: ingress_tready[0] stays 0 and egress_tvalid stays 0 for 20 cycles.
- Backpressure:
  - Stimulus: egress_tready toggles 1,0,0,1 during a 4-beat frame.
  - Required: no beat lost or duplicated; egress_tdata is stable while stalled; no abort even after 10 stalled cycles.
- Watchdog abort:
  - Stimulus: W=3; input 1 sends 2 beats, then drops tvalid for 7 cycles, then sends 3 more beats ending in tlast.
  - Required: egress shows 2 beats, then a beat with tdata=0, tlast=1, tuser=1; the 3 late beats are consumed and not forwarded; the next frame is granted normally.
- Reset mid-frame:
  - Stimulus: assert reset low during beat 2 of 4.
  - Required: egress_tvalid=0 and ingress_tready=0 asynchronously; after release, state=IDLE and a fresh frame on input 3 is granted first.
